nf10_axis_pkt_gen: RTL and testbench

Synthesizable, parametrised AXI4-Stream packet generator that drives C_NUM_PORTS slave ports of an input arbiter, or any multi-port stream sink, with Ethernet-framed test packets. It replaces ad-hoc bench stimulus with a register-driven source:
- fully AXI-compliant (tvalid/tdata held until tready);
- configurable header, payload length and inter-packet gap;
- three port-selection modes;
- packet-count limit;
- NetFPGA-style tuser metadata.

It sits in front of the arbiter, in simulation or in on-chip self-test builds.

---
 rtl/nf10_axis_pkt_gen_if.sv | 17 +
 rtl/nf10_axis_pkt_gen.sv | 234 +++++++++++++++++++++++
 tb/tb_nf10_axis_pkt_gen.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nf10_axis_pkt_gen_if.sv
// Multi-port AXI4-Stream bundle from the packet generator into an N-port sink.
// Each per-port field sits in its own slice of a packed vector.
interface nf10_axis_pkt_gen_if #(
    parameter int C_AXIS_DATA_WIDTH = 64,
    parameter int C_USER_WIDTH      = 128,
    parameter int C_NUM_PORTS       = 5
);
    logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]   tdata;
    logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0] tstrb;
    logic [C_NUM_PORTS*C_USER_WIDTH-1:0]        tuser;
    logic [C_NUM_PORTS-1:0]                     tvalid;
    logic [C_NUM_PORTS-1:0]                     tready;
    logic [C_NUM_PORTS-1:0]                     tlast;

    modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/nf10_axis_pkt_gen.sv
// Register-driven AXI4-Stream Ethernet test-packet source driving one of N ports.
// state   | meaning
// IDLE    | waiting for enable and packet limit not yet reached
// HDR0    | presenting first header beat (dest MAC)
// HDR1    | presenting second header beat (src MAC + EtherType)
// PAYLOAD | presenting payload beat k = beat_q
// GAP     | inter-packet idle, down-counting gap_q to zero
module nf10_axis_pkt_gen #(
    parameter int          C_AXIS_DATA_WIDTH = 64,
    parameter int          C_USER_WIDTH      = 128,
    parameter int          C_NUM_PORTS       = 5,
    parameter logic [15:0] C_LFSR_SEED       = 16'hACE1
) (
    input  logic                         axi_aclk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [15:0]                  num_packets,
    input  logic [7:0]                   payload_words,
    input  logic [7:0]                   gap_cycles,
    input  logic [1:0]                   port_mode,
    input  logic [2:0]                   fixed_port,
    input  logic [C_AXIS_DATA_WIDTH-1:0] hdr_word_0,
    input  logic [C_AXIS_DATA_WIDTH-1:0] hdr_word_1,
    nf10_axis_pkt_gen_if.master          m_axis,
    output logic [31:0]                  pkt_count,
    output logic                         busy,
    output logic                         done
);
    localparam int BYTES = C_AXIS_DATA_WIDTH / 8;
    localparam int W     = C_AXIS_DATA_WIDTH;
    localparam int U     = C_USER_WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_PAYLOAD, S_GAP} state_t;

    state_t         state, state_n;
    logic           en_q;
    logic [15:0]    lfsr, lfsr_n, lfsr_adv;
    logic [2:0]     rr_idx, rr_n, rr_next;
    logic [2:0]     port_q, port_n, sel_port;
    logic [7:0]     pw_q, pw_n;
    logic [W-1:0]   hdr1_q, hdr1_n;
    logic [7:0]     beat_q, beat_n;
    logic [7:0]     gap_q, gap_n;
    logic [15:0]    sent_q, sent_n, sent_inc;
    logic           vld_q, vld_n, last_q, last_n;
    logic [W-1:0]   data_q, data_n;
    logic [U-1:0]   user_q, user_n;
    logic [31:0]    pkt_n;
    logic           done_n;
    logic [7:0]     rdy8;
    logic           hs, limit_hit, limit_after, start, finish;
    logic [15:0]    pkt_len;
    logic [C_NUM_PORTS-1:0] act_n;

    assign rdy8      = 8'(m_axis.tready);
    assign hs        = vld_q & rdy8[port_q];
    assign limit_hit = (num_packets != 16'd0) && (sent_q >= num_packets);
    assign sent_inc  = sent_q + 16'd1;
    assign limit_after = (num_packets != 16'd0) && (sent_inc >= num_packets);
    assign lfsr_adv  = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    assign rr_next   = (rr_idx == 3'(C_NUM_PORTS - 1)) ? 3'd0 : rr_idx + 3'd1;
    assign pkt_len   = (16'(payload_words) + 16'd2) * 16'(BYTES);

    always_comb begin
        sel_port = 3'd0;
        case (port_mode)
            2'd1:    sel_port = rr_idx;
            2'd2:    sel_port = 3'(lfsr[7:0] % 8'(C_NUM_PORTS));
            default: sel_port = ({1'b0, fixed_port} >= 4'(C_NUM_PORTS)) ? 3'd0 : fixed_port;
        endcase
    end

    always_comb begin
        state_n = state;
        lfsr_n  = lfsr;
        rr_n    = rr_idx;
        port_n  = port_q;
        pw_n    = pw_q;
        hdr1_n  = hdr1_q;
        beat_n  = beat_q;
        gap_n   = gap_q;
        sent_n  = sent_q;
        vld_n   = vld_q;
        last_n  = last_q;
        data_n  = data_q;
        user_n  = user_q;
        pkt_n   = pkt_count;
        done_n  = 1'b0;
        start   = 1'b0;
        finish  = 1'b0;

        case (state)
            S_IDLE: begin
                if (!en_q)
                    sent_n = 16'd0;
                else if (!limit_hit)
                    start = 1'b1;
            end
            S_HDR0: begin
                if (hs) begin
                    state_n = S_HDR1;
                    data_n  = hdr1_q;
                    last_n  = (pw_q == 8'd0);
                end
            end
            S_HDR1: begin
                if (hs) begin
                    if (pw_q == 8'd0) begin
                        finish = 1'b1;
                    end else begin
                        state_n = S_PAYLOAD;
                        beat_n  = 8'd0;
                        data_n  = '0;
                        last_n  = (pw_q == 8'd1);
                    end
                end
            end
            S_PAYLOAD: begin
                if (hs) begin
                    if (last_q) begin
                        finish = 1'b1;
                    end else begin
                        beat_n = beat_q + 8'd1;
                        data_n = {BYTES{beat_q + 8'd1}};
                        last_n = (({1'b0, beat_q} + 9'd2) == {1'b0, pw_q});
                    end
                end
            end
            S_GAP: begin
                if (gap_q == 8'd0) begin
                    if (!en_q || limit_hit)
                        state_n = S_IDLE;
                    else
                        start = 1'b1;
                end else begin
                    gap_n = gap_q - 8'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // gap_q holds G-1 so the GAP state lasts exactly G cycles
        if (finish) begin
            pkt_n  = pkt_count + 32'd1;
            sent_n = sent_inc;
            done_n = (num_packets != 16'd0) && (sent_inc == num_packets);
            vld_n  = 1'b0;
            last_n = 1'b0;
            data_n = '0;
            user_n = '0;
            if ((gap_cycles == 8'd0) && en_q && !limit_after) begin
                start = 1'b1;
            end else begin
                state_n = S_GAP;
                gap_n   = (gap_cycles == 8'd0) ? 8'd0 : gap_cycles - 8'd1;
            end
        end

        if (start) begin
            state_n = S_HDR0;
            pw_n    = payload_words;
            hdr1_n  = hdr_word_1;
            port_n  = sel_port;
            lfsr_n  = lfsr_adv;
            if (port_mode == 2'd1)
                rr_n = rr_next;
            beat_n  = 8'd0;
            vld_n   = 1'b1;
            last_n  = 1'b0;
            data_n  = hdr_word_0;
            user_n  = '0;
            user_n[15:0]  = pkt_len;
            user_n[23:16] = 8'd1 << sel_port;
        end
    end

    always_comb begin
        act_n = '0;
        for (int p = 0; p < C_NUM_PORTS; p++)
            act_n[p] = vld_n && (port_n == 3'(p));
    end

    always_ff @(posedge axi_aclk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            en_q      <= 1'b0;
            lfsr      <= C_LFSR_SEED;
            rr_idx    <= 3'd0;
            port_q    <= 3'd0;
            pw_q      <= 8'd0;
            hdr1_q    <= '0;
            beat_q    <= 8'd0;
            gap_q     <= 8'd0;
            sent_q    <= 16'd0;
            vld_q     <= 1'b0;
            last_q    <= 1'b0;
            data_q    <= '0;
            user_q    <= '0;
            pkt_count <= 32'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            m_axis.tvalid <= '0;
            m_axis.tlast  <= '0;
            m_axis.tdata  <= '0;
            m_axis.tstrb  <= '0;
            m_axis.tuser  <= '0;
        end else begin
            state     <= state_n;
            en_q      <= enable;
            lfsr      <= lfsr_n;
            rr_idx    <= rr_n;
            port_q    <= port_n;
            pw_q      <= pw_n;
            hdr1_q    <= hdr1_n;
            beat_q    <= beat_n;
            gap_q     <= gap_n;
            sent_q    <= sent_n;
            vld_q     <= vld_n;
            last_q    <= last_n;
            data_q    <= data_n;
            user_q    <= user_n;
            pkt_count <= pkt_n;
            busy      <= (state_n != S_IDLE);
            done      <= done_n;
            for (int p = 0; p < C_NUM_PORTS; p++) begin
                m_axis.tvalid[p]              <= act_n[p];
                m_axis.tlast[p]               <= act_n[p] & last_n;
                m_axis.tdata[p*W +: W]        <= act_n[p] ? data_n : '0;
                m_axis.tstrb[p*BYTES +: BYTES] <= act_n[p] ? {BYTES{1'b1}} : '0;
                m_axis.tuser[p*U +: U]        <= act_n[p] ? user_n : '0;
            end
        end
    end
endmodule

// File: tb/tb_nf10_axis_pkt_gen.sv
// Directed self-checking bench for nf10_axis_pkt_gen: beat log on the falling edge,
// hand-computed packet contents, port sequences and timing.
module tb_nf10_axis_pkt_gen;
    localparam int W = 64;
    localparam int U = 128;
    localparam int N = 5;
    localparam int LOG = 512;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [15:0]   num_packets = '0;
    logic [7:0]    payload_words = '0;
    logic [7:0]    gap_cycles = '0;
    logic [1:0]    port_mode = '0;
    logic [2:0]    fixed_port = '0;
    logic [W-1:0]  hdr0 = 64'h0011_2233_4455_6677;
    logic [W-1:0]  hdr1 = 64'h8899_AABB_CCDD_0800;
    logic [31:0]   pkt_count;
    logic          busy, done;
    logic          rdy_rand = 1'b0;

    int n_checks = 0;
    int n_pass = 0;

    nf10_axis_pkt_gen_if #(.C_AXIS_DATA_WIDTH(W), .C_USER_WIDTH(U), .C_NUM_PORTS(N)) axis ();

    nf10_axis_pkt_gen #(
        .C_AXIS_DATA_WIDTH(W), .C_USER_WIDTH(U), .C_NUM_PORTS(N), .C_LFSR_SEED(16'hACE1)
    ) dut (
        .axi_aclk(clk), .reset(reset), .enable(enable), .num_packets(num_packets),
        .payload_words(payload_words), .gap_cycles(gap_cycles), .port_mode(port_mode),
        .fixed_port(fixed_port), .hdr_word_0(hdr0), .hdr_word_1(hdr1), .m_axis(axis),
        .pkt_count(pkt_count), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // monitor state: beat log, done pulses, protocol violations
    int            nb = 0, ndone = 0, viol = 0, stab_err = 0, cyc = 0;
    int            lg_port [LOG];
    logic [W-1:0]  lg_data [LOG];
    logic          lg_last [LOG];
    logic [U-1:0]  lg_user [LOG];
    int            lg_cyc  [LOG];
    logic [N-1:0]  pv = '0, pr = '0;
    logic [W-1:0]  pd [N];
    logic [U-1:0]  pu [N];
    logic          pl [N];

    always @(negedge clk) begin
        if (reset) begin
            pv = '0;
        end else begin
            cyc++;
            if ($countones(axis.tvalid) > 1) viol++;
            if (done) ndone++;
            for (int p = 0; p < N; p++) begin
                if (pv[p] && !pr[p] &&
                    !(axis.tvalid[p] && axis.tdata[p*W +: W] === pd[p] &&
                      axis.tuser[p*U +: U] === pu[p] && axis.tlast[p] === pl[p]))
                    stab_err++;
                if (axis.tvalid[p] && axis.tready[p] && nb < LOG) begin
                    lg_port[nb] = p;
                    lg_data[nb] = axis.tdata[p*W +: W];
                    lg_last[nb] = axis.tlast[p];
                    lg_user[nb] = axis.tuser[p*U +: U];
                    lg_cyc[nb]  = cyc;
                    nb++;
                end
                pv[p] = axis.tvalid[p];
                pr[p] = axis.tready[p];
                pd[p] = axis.tdata[p*W +: W];
                pu[p] = axis.tuser[p*U +: U];
                pl[p] = axis.tlast[p];
            end
        end
    end

    initial begin
        axis.tready = '1;
        forever begin
            @(posedge clk);
            #1;
            axis.tready = rdy_rand ? N'($urandom) : '1;
        end
    end

    task automatic check(input string tag, input logic [U-1:0] got, input logic [U-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        enable = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic wait_beats(input string tag, input int n, input int maxc);
        int c = 0;
        while (nb < n && c < maxc) begin step(); c++; end
        check(tag, U'(nb >= n), U'(1));
    endtask

    task automatic wait_done(input string tag, input int n, input int maxc);
        int c = 0;
        while (ndone < n && c < maxc) begin step(); c++; end
        check(tag, U'(ndone >= n), U'(1));
    endtask

    task automatic wait_idle(input string tag, input int maxc);
        int c = 0;
        while (busy && c < maxc) begin step(); c++; end
        check(tag, U'(busy), U'(0));
    endtask

    // compares one logged packet against the expected beat sequence
    task automatic check_pkt(input string tag, input int base, input int port, input int pw);
        logic [W-1:0] ed;
        logic [U-1:0] eu;
        eu = '0;
        eu[15:0]  = 16'((pw + 2) * (W / 8));
        eu[23:16] = 8'(1 << port);
        for (int i = 0; i < pw + 2; i++) begin
            if (i == 0)      ed = hdr0;
            else if (i == 1) ed = hdr1;
            else             for (int b = 0; b < W / 8; b++) ed[8*b +: 8] = 8'(i - 2);
            check({tag, "_data"}, U'(lg_data[base+i]), U'(ed));
            check({tag, "_last"}, U'(lg_last[base+i]), U'(i == pw + 1));
            check({tag, "_port"}, U'(lg_port[base+i]), U'(port));
            check({tag, "_user"}, lg_user[base+i], eu);
        end
    endtask

    initial begin
        int b, d0, maxp;
        logic [15:0] l;

        // reset state
        step();
        check("rst_tvalid", U'(axis.tvalid), U'(0));
        check("rst_tdata", U'(axis.tdata), U'(0));
        check("rst_tuser", axis.tuser[U-1:0], U'(0));
        check("rst_pkt_count", U'(pkt_count), U'(0));
        reset = 1'b0;
        step();
        check("rst_busy", U'(busy), U'(0));
        check("rst_done", U'(done), U'(0));
        check("rst_tstrb", U'(axis.tstrb), U'(0));

        // fixed port 2, 31-word payload, single packet
        port_mode = 2'd0; fixed_port = 3'd2; payload_words = 8'd31;
        gap_cycles = 8'd128; num_packets = 16'd1;
        b = nb; d0 = ndone;
        enable = 1'b1;
        step();
        check("lat_early_tvalid", U'(axis.tvalid), U'(0));
        step();
        check("lat_tvalid", U'(axis.tvalid), U'(5'b00100));
        check("lat_tstrb", U'(axis.tstrb), U'(40'h00_00FF_0000));
        wait_done("t1_done_tmo", d0 + 1, 400);
        repeat (200) step();
        check("t1_beats", U'(nb - b), U'(33));
        check("t1_done_cnt", U'(ndone - d0), U'(1));
        check("t1_pkt_count", U'(pkt_count), U'(1));
        check("t1_busy", U'(busy), U'(0));
        check_pkt("t1", b, 2, 31);
        check("t1_tuser_len", U'(lg_user[b][23:0]), U'(24'h04_0108));

        // round-robin, header-only packets, back-to-back
        do_reset();
        port_mode = 2'd1; payload_words = 8'd0; gap_cycles = 8'd0; num_packets = 16'd7;
        b = nb; d0 = ndone;
        enable = 1'b1;
        wait_done("t2_done_tmo", d0 + 1, 100);
        step();
        check("t2_beats", U'(nb - b), U'(14));
        check("t2_pkt_count", U'(pkt_count), U'(7));
        check("t2_b2b", U'(lg_cyc[b+13] - lg_cyc[b]), U'(13));
        for (int i = 0; i < 7; i++) check_pkt("t2", b + 2 * i, i % 5, 0);

        // backpressure with random tready
        do_reset();
        port_mode = 2'd0; fixed_port = 3'd3; payload_words = 8'd6;
        gap_cycles = 8'd2; num_packets = 16'd3;
        b = nb; d0 = ndone; stab_err = 0;
        rdy_rand = 1'b1;
        enable = 1'b1;
        wait_done("t3_done_tmo", d0 + 1, 2000);
        rdy_rand = 1'b0;
        step();
        check("t3_beats", U'(nb - b), U'(24));
        check("t3_stable", U'(stab_err), U'(0));
        check("t3_pkt_count", U'(pkt_count), U'(3));
        for (int i = 0; i < 3; i++) check_pkt("t3", b + 8 * i, 3, 6);

        // out-of-range fixed port maps to 0; gap of 3 cycles
        do_reset();
        port_mode = 2'd0; fixed_port = 3'd7; payload_words = 8'd1;
        gap_cycles = 8'd3; num_packets = 16'd2;
        b = nb; d0 = ndone;
        enable = 1'b1;
        wait_done("t4_done_tmo", d0 + 1, 100);
        check("t4_beats", U'(nb - b), U'(6));
        check("t4_gap", U'(lg_cyc[b+3] - lg_cyc[b+2]), U'(4));
        check_pkt("t4a", b, 0, 1);
        check_pkt("t4b", b + 3, 0, 1);

        // LFSR port selection over 100 packets
        do_reset();
        port_mode = 2'd2; payload_words = 8'd0; gap_cycles = 8'd0; num_packets = 16'd100;
        b = nb; d0 = ndone;
        enable = 1'b1;
        wait_done("t5_done_tmo", d0 + 1, 600);
        check("t5_beats", U'(nb - b), U'(200));
        l = 16'hACE1;
        maxp = 0;
        for (int i = 0; i < 100; i++) begin
            check("t5_port", U'(lg_port[b+2*i]), U'(int'(l[7:0]) % N));
            if (lg_port[b+2*i] > maxp) maxp = lg_port[b+2*i];
            l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
        end
        check("t5_port_range", U'(maxp < N), U'(1));

        // enable dropped during payload beat 5
        do_reset();
        port_mode = 2'd0; fixed_port = 3'd1; payload_words = 8'd31;
        gap_cycles = 8'd4; num_packets = 16'd0;
        b = nb;
        enable = 1'b1;
        wait_beats("t6_beat5_tmo", b + 7, 50);
        enable = 1'b0;
        wait_idle("t6_idle_tmo", 100);
        repeat (20) step();
        check("t6_beats", U'(nb - b), U'(33));
        check("t6_pkt_count", U'(pkt_count), U'(1));
        check("t6_tvalid", U'(axis.tvalid), U'(0));
        check_pkt("t6", b, 1, 31);

        // reset during HDR1, then restart from round-robin port 0
        do_reset();
        port_mode = 2'd1; payload_words = 8'd3; gap_cycles = 8'd0; num_packets = 16'd0;
        b = nb;
        enable = 1'b1;
        wait_beats("t7_hdr1_tmo", b + 11, 100);
        check("t7_pre_pkt_count", U'(pkt_count), U'(2));
        check("t7_pre_tvalid", U'(axis.tvalid), U'(5'b00100));
        reset = 1'b1;
        #1;
        check("t7_rst_tvalid", U'(axis.tvalid), U'(0));
        check("t7_rst_pkt_count", U'(pkt_count), U'(0));
        step();
        step();
        b = nb;
        reset = 1'b0;
        wait_beats("t7_restart_tmo", b + 1, 20);
        check("t7_restart_port", U'(lg_port[b]), U'(0));
        check("t7_restart_data", U'(lg_data[b]), U'(hdr0));

        check("one_hot_tvalid", U'(viol), U'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
